// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmit path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_pkg;

    // Transmit FSM states, in on-wire order of a frame.
    typedef enum logic [2:0] {
        SERIAL_TX_IDLE  = 3'd0,
        SERIAL_TX_START = 3'd1,
        SERIAL_TX_DATA  = 3'd2,
        SERIAL_TX_NINTH = 3'd3,
        SERIAL_TX_STOP  = 3'd4
    } serial_tx_state_e;

    // Legal parameter ceilings; counters are sized for the worst case so
    // every legal parameter set shares one set of widths.
    localparam int SERIAL_MAX_DATA_W     = 9;
    localparam int SERIAL_MAX_OVERSAMPLE = 64;

    // Tick counter holds 0..OVERSAMPLE-1, bit counter holds 0..DATA_W-1.
    localparam int SERIAL_TICK_CNT_W = $clog2(SERIAL_MAX_OVERSAMPLE);
    localparam int SERIAL_BIT_CNT_W  = $clog2(SERIAL_MAX_DATA_W);

    localparam int SERIAL_START_BITS = 1;

    // Bits on the wire for one frame; multiply by OVERSAMPLE for ticks.
    function automatic int serial_frame_bits(input int data_w,
                                             input logic ninth,
                                             input int stop_bits);
        return SERIAL_START_BITS + data_w + (ninth ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/serial_tick_div.sv
// Baud tick extraction and per-bit oversample counter.
// Latency: tick is combinational from serial_br_i; br_q and the counter are registered.
// Backpressure: none; clr_i holds the counter at 0 so the first bit aligns to a tick.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   br_i           baud reference level; each rising edge is one tick
//   clr_i          hold the counter at 0 (line idle)
//   tick_o         one-cycle baud tick
//   bit_boundary_o tick on which the counter wraps to 0
module serial_tick_div
    import serial_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic br_i,
    input  logic clr_i,
    output logic tick_o,
    output logic bit_boundary_o
);

    localparam logic [SERIAL_TICK_CNT_W-1:0] CNT_MAX = SERIAL_TICK_CNT_W'(OVERSAMPLE - 1);

    logic                         br_q, br_d;
    logic [SERIAL_TICK_CNT_W-1:0] cnt_q, cnt_d;
    logic                         at_max;

    always_comb begin
        br_d           = br_i;
        tick_o         = br_i & ~br_q;
        at_max         = (cnt_q == CNT_MAX);
        // No boundary while cleared: the tick that leaves idle is the
        // first tick of the start bit, not the end of one.
        bit_boundary_o = tick_o & at_max & ~clr_i;
        cnt_d          = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = at_max ? '0 : cnt_q + SERIAL_TICK_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            br_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            br_q  <= br_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx_gen.sv
// UART transmitter: 8/9-bit async frames with a one-deep holding buffer.
// Latency: TXD falls on the first baud tick after the strobe is registered; outputs registered.
// Backpressure: none upstream; a strobe with the holding buffer full is dropped and flagged on overrun.
//
// Ports:
//   serial_clock_i      system clock
//   serial_reset_i_b    asynchronous active-low reset
//   serial_br_i         baud reference level
//   serial_scon_9bit_i  0 = 8-bit frame, 1 = 9-bit frame (sampled at START entry)
//   serial_scon3_tb8_i  ninth data bit for 9-bit frames
//   serial_serial_tx_i  one-cycle SBUF write strobe
//   serial_data_sbuf_i  data captured on the strobe
//   serial_data_tx_o    TXD line (idle 1)
//   serial_data_en_o    pad enable, START through end of STOP
//   serial_scon1_ti_o   one-cycle TI pulse on STOP entry
//   serial_busy_o       frame in progress, pending or buffer occupied
//   serial_overrun_o    one-cycle pulse when a strobe is dropped
//
// Build option: define SERIAL_TX_PARITY_EN to send even parity of the data
// bits as the ninth bit in 9-bit mode instead of serial_scon3_tb8_i.
module serial_tx_gen
    import serial_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic              serial_clock_i,
    input  logic              serial_reset_i_b,
    input  logic              serial_br_i,
    input  logic              serial_scon_9bit_i,
    input  logic              serial_scon3_tb8_i,
    input  logic              serial_serial_tx_i,
    input  logic [DATA_W-1:0] serial_data_sbuf_i,
    output logic              serial_data_tx_o,
    output logic              serial_data_en_o,
    output logic              serial_scon1_ti_o,
    output logic              serial_busy_o,
    output logic              serial_overrun_o
);

    localparam logic [SERIAL_BIT_CNT_W-1:0] DATA_LAST = SERIAL_BIT_CNT_W'(DATA_W - 1);
    localparam logic [SERIAL_BIT_CNT_W-1:0] STOP_LAST = SERIAL_BIT_CNT_W'(STOP_BITS - 1);

    serial_tx_state_e            state_q, state_d;
    logic [DATA_W-1:0]           shreg_q, shreg_d;
    logic                        ninth_q, ninth_d;
    logic                        mode9_q, mode9_d;
    logic [SERIAL_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                        pending_q, pending_d;
    logic                        buf_full_q, buf_full_d;
    logic [DATA_W-1:0]           buf_dat_q, buf_dat_d;
    logic                        buf_ninth_q, buf_ninth_d;
    logic                        txd_q, txd_d;
    logic                        en_q, en_d;
    logic                        ti_q, ti_d;
    logic                        busy_q, busy_d;
    logic                        ovr_q, ovr_d;

    logic tick;
    logic bit_boundary;
    logic strobe_ninth;
    logic strobe_taken;

    serial_tick_div #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick_div (
        .clk_i          (serial_clock_i),
        .rst_ni         (serial_reset_i_b),
        .br_i           (serial_br_i),
        .clr_i          (state_q == SERIAL_TX_IDLE),
        .tick_o         (tick),
        .bit_boundary_o (bit_boundary)
    );

    // Ninth bit travels with the data it belongs to, so it is resolved at
    // strobe time whether the data goes to the shifter or the buffer.
`ifdef SERIAL_TX_PARITY_EN
    assign strobe_ninth = ^serial_data_sbuf_i;
`else
    assign strobe_ninth = serial_scon3_tb8_i;
`endif

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        ninth_d      = ninth_q;
        mode9_d      = mode9_q;
        bit_cnt_d    = bit_cnt_q;
        pending_d    = pending_q;
        buf_full_d   = buf_full_q;
        buf_dat_d    = buf_dat_q;
        buf_ninth_d  = buf_ninth_q;
        ovr_d        = 1'b0;
        strobe_taken = 1'b0;

        unique case (state_q)
            SERIAL_TX_IDLE: begin
                if (pending_q && tick) begin
                    state_d   = SERIAL_TX_START;
                    bit_cnt_d = '0;
                    pending_d = 1'b0;
                end
            end
            SERIAL_TX_START: begin
                if (bit_boundary) begin
                    state_d   = SERIAL_TX_DATA;
                    bit_cnt_d = '0;
                end
            end
            SERIAL_TX_DATA: begin
                if (bit_boundary) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        state_d   = mode9_q ? SERIAL_TX_NINTH : SERIAL_TX_STOP;
                        bit_cnt_d = '0;
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + SERIAL_BIT_CNT_W'(1);
                    end
                end
            end
            SERIAL_TX_NINTH: begin
                if (bit_boundary) begin
                    state_d   = SERIAL_TX_STOP;
                    bit_cnt_d = '0;
                end
            end
            SERIAL_TX_STOP: begin
                if (bit_boundary) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d = '0;
                        if (buf_full_q) begin
                            // Buffered frame follows with no idle bit.
                            state_d    = SERIAL_TX_START;
                            shreg_d    = buf_dat_q;
                            ninth_d    = buf_ninth_q;
                            buf_full_d = 1'b0;
                        end else if (serial_serial_tx_i) begin
                            // Strobe landing exactly on the last stop
                            // boundary bypasses the empty buffer.
                            state_d      = SERIAL_TX_START;
                            shreg_d      = serial_data_sbuf_i;
                            ninth_d      = strobe_ninth;
                            strobe_taken = 1'b1;
                        end else begin
                            state_d = SERIAL_TX_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + SERIAL_BIT_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = SERIAL_TX_IDLE;
            end
        endcase

        // Strobe is resolved after any buffer-to-shifter transfer above, so
        // a strobe in the transfer cycle refills the freshly emptied buffer.
        if (serial_serial_tx_i && !strobe_taken) begin
            if (state_q == SERIAL_TX_IDLE && !pending_q) begin
                shreg_d   = serial_data_sbuf_i;
                ninth_d   = strobe_ninth;
                pending_d = 1'b1;
            end else if (!buf_full_d) begin
                buf_dat_d   = serial_data_sbuf_i;
                buf_ninth_d = strobe_ninth;
                buf_full_d  = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end

        if (state_d == SERIAL_TX_START && state_q != SERIAL_TX_START) begin
            mode9_d = serial_scon_9bit_i;
        end

        unique case (state_d)
            SERIAL_TX_START: txd_d = 1'b0;
            SERIAL_TX_DATA:  txd_d = shreg_d[0];
            SERIAL_TX_NINTH: txd_d = ninth_d;
            default:         txd_d = 1'b1;
        endcase

        en_d   = (state_d != SERIAL_TX_IDLE);
        ti_d   = (state_d == SERIAL_TX_STOP) && (state_q != SERIAL_TX_STOP);
        busy_d = (state_d != SERIAL_TX_IDLE) || pending_d || buf_full_d;
    end

    always_ff @(posedge serial_clock_i or negedge serial_reset_i_b) begin
        if (!serial_reset_i_b) begin
            state_q     <= SERIAL_TX_IDLE;
            shreg_q     <= '0;
            ninth_q     <= 1'b0;
            mode9_q     <= 1'b0;
            bit_cnt_q   <= '0;
            pending_q   <= 1'b0;
            buf_full_q  <= 1'b0;
            buf_dat_q   <= '0;
            buf_ninth_q <= 1'b0;
            txd_q       <= 1'b1;
            en_q        <= 1'b0;
            ti_q        <= 1'b0;
            busy_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            ninth_q     <= ninth_d;
            mode9_q     <= mode9_d;
            bit_cnt_q   <= bit_cnt_d;
            pending_q   <= pending_d;
            buf_full_q  <= buf_full_d;
            buf_dat_q   <= buf_dat_d;
            buf_ninth_q <= buf_ninth_d;
            txd_q       <= txd_d;
            en_q        <= en_d;
            ti_q        <= ti_d;
            busy_q      <= busy_d;
            ovr_q       <= ovr_d;
        end
    end

    assign serial_data_tx_o  = txd_q;
    assign serial_data_en_o  = en_q;
    assign serial_scon1_ti_o = ti_q;
    assign serial_busy_o     = busy_q;
    assign serial_overrun_o  = ovr_q;

endmodule

// File: tb/tb_serial_tx_gen.sv
// Directed bench for serial_tx_gen: 8/9-bit frames, buffering, overrun,
// mid-frame reset and a long-frame timing check on a second instance.
// br period is 8 clocks; dut uses OVERSAMPLE=1, dut2 OVERSAMPLE=4, STOP_BITS=2.
module tb_serial_tx_gen;

    logic       clk;
    logic       rst_n;
    logic       br;
    logic       mode9;
    logic       tb8;
    logic       strobe;
    logic       strobe2;
    logic [7:0] data;

    logic txd, en, ti, busy, ovr;
    logic txd2, en2, ti2, busy2, ovr2;

    int checks   = 0;
    int passes   = 0;
    int ti_cnt   = 0;
    int ovr_cnt  = 0;
    int tick_cnt = 0;

    logic [31:0] cap_bits;
    logic [31:0] cap_ti;

    serial_tx_gen #(
        .DATA_W     (8),
        .OVERSAMPLE (1),
        .STOP_BITS  (1)
    ) dut (
        .serial_clock_i     (clk),
        .serial_reset_i_b   (rst_n),
        .serial_br_i        (br),
        .serial_scon_9bit_i (mode9),
        .serial_scon3_tb8_i (tb8),
        .serial_serial_tx_i (strobe),
        .serial_data_sbuf_i (data),
        .serial_data_tx_o   (txd),
        .serial_data_en_o   (en),
        .serial_scon1_ti_o  (ti),
        .serial_busy_o      (busy),
        .serial_overrun_o   (ovr)
    );

    serial_tx_gen #(
        .DATA_W     (8),
        .OVERSAMPLE (4),
        .STOP_BITS  (2)
    ) dut2 (
        .serial_clock_i     (clk),
        .serial_reset_i_b   (rst_n),
        .serial_br_i        (br),
        .serial_scon_9bit_i (1'b0),
        .serial_scon3_tb8_i (1'b0),
        .serial_serial_tx_i (strobe2),
        .serial_data_sbuf_i (data),
        .serial_data_tx_o   (txd2),
        .serial_data_en_o   (en2),
        .serial_scon1_ti_o  (ti2),
        .serial_busy_o      (busy2),
        .serial_overrun_o   (ovr2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud reference: 4 clocks low, 4 high; tick_cnt counts rising edges.
    initial begin
        br = 1'b0;
        forever begin
            repeat (4) @(posedge clk);
            #1 br = ~br;
            if (br) tick_cnt++;
        end
    end

    always @(negedge clk) begin
        if (ti === 1'b1)  ti_cnt++;
        if (ovr === 1'b1) ovr_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] d);
        @(posedge clk);
        #1;
        data   = d;
        strobe = 1'b1;
        @(posedge clk);
        #1;
        strobe = 1'b0;
    endtask

    task automatic send2(input logic [7:0] d);
        @(posedge clk);
        #1;
        data    = d;
        strobe2 = 1'b1;
        @(posedge clk);
        #1;
        strobe2 = 1'b0;
    endtask

    // Waits for the start bit, then samples txd/ti once per bit (8 clocks).
    task automatic capture(input int nbits, input string name);
        int waited = 0;
        cap_bits = '0;
        cap_ti   = '0;
        @(negedge clk);
        while (txd !== 1'b0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (txd !== 1'b0) begin
            checks++;
            $display("FAIL %s_start: txd=%b after 300 cycles, required 0", name, txd);
            return;
        end
        for (int k = 0; k < nbits; k++) begin
            if (k != 0) repeat (8) @(negedge clk);
            cap_bits[k] = txd;
            cap_ti[k]   = ti;
        end
    endtask

    task automatic wait_idle(input string name);
        int waited = 0;
        while (busy !== 1'b0 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (busy !== 1'b0) begin
            checks++;
            $display("FAIL %s_idle: busy=%b after 500 cycles, required 0", name, busy);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (txd !== 1'b1)  $display("FAIL reset_txd: got %b, required 1", txd);   else passes++;
        checks++; if (en !== 1'b0)   $display("FAIL reset_en: got %b, required 0", en);     else passes++;
        checks++; if (ti !== 1'b0)   $display("FAIL reset_ti: got %b, required 0", ti);     else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else passes++;
        checks++; if (ovr !== 1'b0)  $display("FAIL reset_ovr: got %b, required 0", ovr);   else passes++;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_8bit;
        int ti0;
        mode9 = 1'b0;
        ti0   = ti_cnt;
        send(8'h33);
        checks++; if (busy !== 1'b1) $display("FAIL busy_rise: got %b, required 1", busy); else passes++;
        capture(10, "frame_33");
        checks++;
        if (cap_bits[9:0] !== {1'b1, 8'h33, 1'b0})
            $display("FAIL frame_33: got %b, required %b", cap_bits[9:0], {1'b1, 8'h33, 1'b0});
        else passes++;
        checks++; if (cap_ti[9:0] !== 10'h200) $display("FAIL ti_at_stop_33: got %h, required 200", cap_ti[9:0]); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL busy_in_stop: got %b, required 1", busy); else passes++;
        repeat (8) @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL busy_fall: got %b, required 0", busy); else passes++;
        checks++; if (en !== 1'b0)   $display("FAIL en_after_stop: got %b, required 0", en); else passes++;
        checks++; if (ti_cnt - ti0 !== 1) $display("FAIL ti_count_33: got %0d, required 1", ti_cnt - ti0); else passes++;
        wait_idle("frame_33");
    endtask

    task automatic test_9bit;
        logic exp_ninth;
        mode9 = 1'b1;
        tb8   = 1'b1;
        send(8'hA2);
        capture(11, "frame_a2");
        checks++;
        if (cap_bits[10:0] !== {1'b1, 1'b1, 8'hA2, 1'b0})
            $display("FAIL frame_a2_9bit: got %b, required %b", cap_bits[10:0], {1'b1, 1'b1, 8'hA2, 1'b0});
        else passes++;
        checks++; if (cap_ti[10:0] !== 11'h400) $display("FAIL ti_at_stop_a2: got %h, required 400", cap_ti[10:0]); else passes++;
        wait_idle("frame_a2");
        // 0x07 has three ones: parity 1, tb8 0.
        tb8 = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        exp_ninth = 1'b1;
`else
        exp_ninth = 1'b0;
`endif
        send(8'h07);
        capture(11, "frame_07");
        checks++;
        if (cap_bits[10:0] !== {1'b1, exp_ninth, 8'h07, 1'b0})
            $display("FAIL frame_07_9bit: got %b, required %b", cap_bits[10:0], {1'b1, exp_ninth, 8'h07, 1'b0});
        else passes++;
        wait_idle("frame_07");
        mode9 = 1'b0;
    endtask

    task automatic test_back_to_back;
        int ti0;
        int ov0;
        ti0 = ti_cnt;
        ov0 = ovr_cnt;
        send(8'h55);
        fork
            capture(20, "b2b");
            begin
                repeat (30) @(posedge clk);
                send(8'h0F);
            end
        join
        checks++;
        if (cap_bits[19:0] !== {1'b1, 8'h0F, 1'b0, 1'b1, 8'h55, 1'b0})
            $display("FAIL b2b_frames: got %b, required %b", cap_bits[19:0], {1'b1, 8'h0F, 1'b0, 1'b1, 8'h55, 1'b0});
        else passes++;
        wait_idle("b2b");
        checks++; if (ti_cnt - ti0 !== 2)  $display("FAIL b2b_ti_count: got %0d, required 2", ti_cnt - ti0); else passes++;
        checks++; if (ovr_cnt - ov0 !== 0) $display("FAIL b2b_overrun: got %0d, required 0", ovr_cnt - ov0); else passes++;
    endtask

    task automatic test_overrun;
        int   ov0;
        logic seen0;
        ov0   = ovr_cnt;
        seen0 = 1'b0;
        fork
            capture(20, "ovr");
            begin
                send(8'h01);
                send(8'h02);
                send(8'h03);
            end
        join
        checks++;
        if (cap_bits[19:0] !== {1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 1'b0})
            $display("FAIL ovr_frames: got %b, required %b", cap_bits[19:0], {1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 1'b0});
        else passes++;
        wait_idle("ovr");
        checks++; if (ovr_cnt - ov0 !== 1) $display("FAIL ovr_pulses: got %0d, required 1", ovr_cnt - ov0); else passes++;
        repeat (100) begin
            @(negedge clk);
            if (txd === 1'b0) seen0 = 1'b1;
        end
        checks++; if (seen0 !== 1'b0) $display("FAIL ovr_third_frame: got start bit %b, required none", seen0); else passes++;
    endtask

    task automatic test_reset_mid_frame;
        int ti0;
        int waited = 0;
        ti0 = ti_cnt;
        send(8'hFF);
        @(negedge clk);
        while (txd !== 1'b0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (txd !== 1'b0) begin
            checks++;
            $display("FAIL rst_mid_start: txd=%b after 300 cycles, required 0", txd);
        end
        repeat (32) @(negedge clk);
        checks++; if (txd !== 1'b1 || en !== 1'b1)
            $display("FAIL rst_mid_bit3: txd=%b en=%b, required 1 1", txd, en); else passes++;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (txd !== 1'b1)  $display("FAIL rst_mid_txd: got %b, required 1", txd);   else passes++;
        checks++; if (en !== 1'b0)   $display("FAIL rst_mid_en: got %b, required 0", en);     else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b, required 0", busy); else passes++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (ti_cnt !== ti0) $display("FAIL rst_mid_no_ti: got %0d pulses, required 0", ti_cnt - ti0); else passes++;
        send(8'h5A);
        capture(10, "after_rst");
        checks++;
        if (cap_bits[9:0] !== {1'b1, 8'h5A, 1'b0})
            $display("FAIL after_rst_frame: got %b, required %b", cap_bits[9:0], {1'b1, 8'h5A, 1'b0});
        else passes++;
        wait_idle("after_rst");
        checks++; if (ti_cnt - ti0 !== 1) $display("FAIL after_rst_ti: got %0d, required 1", ti_cnt - ti0); else passes++;
    endtask

    task automatic test_long_frame;
        int t0;
        int t_ti;
        int t_end;
        int waited;
        t0 = 0; t_ti = 0; t_end = 0;
        send2(8'hC3);
        waited = 0;
        @(negedge clk);
        while (txd2 !== 1'b0 && waited < 400) begin @(negedge clk); waited++; end
        t0 = tick_cnt;
        waited = 0;
        while (ti2 !== 1'b1 && waited < 600) begin @(negedge clk); waited++; end
        t_ti = tick_cnt;
        waited = 0;
        while (en2 !== 1'b0 && waited < 600) begin @(negedge clk); waited++; end
        t_end = tick_cnt;
        checks++; if (t_ti - t0 !== 36)  $display("FAIL long_ti_tick: got %0d, required 36", t_ti - t0);  else passes++;
        checks++; if (t_end - t0 !== 44) $display("FAIL long_frame_ticks: got %0d, required 44", t_end - t0); else passes++;
        repeat (4) @(negedge clk);
        checks++; if (busy2 !== 1'b0 || ovr2 !== 1'b0)
            $display("FAIL long_idle: busy=%b ovr=%b, required 0 0", busy2, ovr2); else passes++;
    endtask

    initial begin
        rst_n   = 1'b0;
        mode9   = 1'b0;
        tb8     = 1'b0;
        strobe  = 1'b0;
        strobe2 = 1'b0;
        data    = 8'h00;
        test_reset();
        test_8bit();
        test_9bit();
        test_back_to_back();
        test_overrun();
        test_reset_mid_frame();
        test_long_frame();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
